// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg
//   Shared definitions for the dff_pipe elastic register pipeline.
//   stage_op_e names the single action a stage register takes at a clock edge,
//   so the priority between reset, flush, enable and load is resolved in one
//   place and the sequential block only has to carry out the chosen action.
// Ports: none (package).

package dff_pipe_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RESET = 2'd3
  } stage_op_e;

endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage
//   One stage of the elastic pipeline: a valid bit plus a WIDTH-bit data
//   register with enable, synchronous flush and synchronous active-low reset.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-low (0 = reset)
//   en         in   global enable; 0 freezes this stage
//   flush      in   synchronous flush; clears the valid bit, keeps data
//   src_valid  in   valid bit of the source (previous stage or input)
//   src_data   in   data of the source
//   load       in   downstream-side ready for this stage; take the source
//   vld        out  stage holds a valid entry
//   dat        out  stage data register

module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             load,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  stage_op_e op;

  // Decide what this stage does at the next edge. Reset beats flush, flush
  // beats a disabled pipe (a flush still clears when en=0), and only an
  // enabled, ready stage loads.
  always_comb begin
    op = OP_HOLD;
    if (!rst) begin
      op = OP_RESET;
    end else if (flush) begin
      op = OP_CLEAR;
    end else if (en && load) begin
      op = OP_LOAD;
    end
  end

  // Carry out the chosen action. On a load the valid bit always follows the
  // source, but data is only written by a valid source so bubbles passing
  // through never disturb the last value held (and hence q).
  always_ff @(posedge clk) begin
    case (op)
      OP_RESET: begin
        vld <= 1'b0;
        dat <= RST_VAL;
      end
      OP_CLEAR: begin
        vld <= 1'b0;
      end
      OP_LOAD: begin
        vld <= src_valid;
        if (src_valid) begin
          dat <= src_data;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe
//   Elastic pipeline of DEPTH enabled register stages, WIDTH bits each, with
//   valid/ready handshaking, bubble collapse, global enable and flush.
//   Used to retime datapath signals between RISC-V pipeline blocks.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-low (0 = reset)
//   en         in   global enable; 0 freezes all state and blocks transfers
//   flush      in   synchronous flush; drops every in-flight entry
//   in_valid   in   upstream offers d
//   in_ready   out  pipe accepts d this cycle
//   d          in   input data
//   out_valid  out  q holds a valid entry
//   out_ready  in   downstream accepts q
//   q          out  last stage data register
//   count      out  number of valid stages (0..DEPTH)

module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] dat [DEPTH];

  // Ready ripples from the output back to the input: a stage can take new
  // data if it is empty or if the stage after it is itself able to move.
  // Built in one block from the output end so no stage reads a later value.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = !vld[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = !vld[i] || rdy[i+1];
    end
  end

  assign in_ready  = rst && !flush && en && rdy[0];
  assign out_valid = vld[DEPTH-1] && en;
  assign q         = dat[DEPTH-1];

  // Occupancy is simply the number of set valid bits, which can never
  // exceed DEPTH, so the counter width is enough and cannot wrap.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(vld[i]);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    // Stage 0 only sees a valid source on a real input handshake; later
    // stages take whatever the stage before them holds.
    if (i == 0) begin : g_first
      assign src_valid = in_valid && in_ready;
      assign src_data  = d;
    end else begin : g_next
      assign src_valid = vld[i-1];
      assign src_data  = dat[i-1];
    end

    dff_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .src_valid (src_valid),
      .src_data  (src_data),
      .load      (rdy[i]),
      .vld       (vld[i]),
      .dat       (dat[i])
    );
  end

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe
//   Self-checking bench for dff_pipe (WIDTH=8, DEPTH=3, RST_VAL=0).
//   The reference model keeps the in-flight entries as a queue, each tagged
//   with its stage position; entries advance toward the output as far as the
//   entry ahead of them allows. Inputs change on the falling edge and outputs
//   are compared a few ns later, well away from the rising edge.

module tb_dff_pipe;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 3;
  localparam logic [7:0] RST_VAL = 8'h00;

  logic       clk;
  logic       rst;
  logic       en;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic [1:0] count;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } entry_t;

  entry_t     sb[$];
  logic [7:0] last_q;
  int         assertions;
  int         failures;

  dff_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .count     (count)
  );

  // 40 ns board-style clock.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Single comparison point: every check counts and reports through here.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against what the model predicts for the current
  // state and the inputs being driven this cycle.
  task automatic check_output(input logic r, input logic e, input logic f,
                              input logic ordy);
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic       head_at_out;
    head_at_out   = (sb.size() > 0) && (sb[0].pos == DEPTH - 1);
    exp_in_ready  = r && !f && e && ((sb.size() < DEPTH) || ordy);
    exp_out_valid = e && head_at_out;
    check("in_ready", 32'(in_ready), 32'(exp_in_ready));
    check("out_valid", 32'(out_valid), 32'(exp_out_valid));
    check("count", 32'(count), 32'(sb.size()));
    check("q", 32'(q), 32'(last_q));
    if (exp_out_valid && ordy) begin
      check("out_data", 32'(q), 32'(sb[0].data));
    end
  endtask

  // Advance the model by one rising edge.
  task automatic model_step(input logic r, input logic e, input logic f,
                            input logic iv, input logic [7:0] dd, input logic ordy);
    bit     accept;
    int     lim;
    int     np;
    entry_t ne;
    accept = r && !f && e && iv && ((sb.size() < DEPTH) || ordy);
    if (!r) begin
      sb.delete();
      last_q = RST_VAL;
    end else if (f) begin
      sb.delete();
    end else if (e) begin
      if (sb.size() > 0 && sb[0].pos == DEPTH - 1 && ordy) begin
        void'(sb.pop_front());
      end
      lim = DEPTH;
      for (int k = 0; k < sb.size(); k++) begin
        np = sb[k].pos + 1;
        if (np > lim - 1) np = lim - 1;
        if (np == DEPTH - 1 && sb[k].pos != DEPTH - 1) last_q = sb[k].data;
        sb[k].pos = np;
        lim = np;
      end
      if (accept) begin
        ne.data = dd;
        ne.pos  = 0;
        sb.push_back(ne);
        if (DEPTH == 1) last_q = dd;
      end
    end
  endtask

  // One clock cycle: drive on the falling edge, check, then step the model.
  task automatic apply_stimulus(input logic r, input logic e, input logic f,
                                input logic iv, input logic [7:0] dd, input logic ordy);
    @(negedge clk);
    rst       = r;
    en        = e;
    flush     = f;
    in_valid  = iv;
    d         = dd;
    out_ready = ordy;
    #5;
    check_output(r, e, f, ordy);
    model_step(r, e, f, iv, dd, ordy);
  endtask

  initial begin
    logic [7:0] bp_data [4];
    int         idx;
    logic       ri;
    logic       ro;
    logic       re;
    logic [7:0] rd;

    assertions = 0;
    failures   = 0;
    last_q     = RST_VAL;
    rst        = 1'b0;
    en         = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b1;
    d          = 8'hAA;
    out_ready  = 1'b1;

    // Let two edges pass under reset so the registers leave X.
    @(negedge clk);
    @(negedge clk);

    $display("[TB] reset");
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
    check("reset_q", 32'(q), 32'h00);
    check("reset_count", 32'(count), 32'd0);

    $display("[TB] latency and streaming");
    for (int i = 1; i <= 5; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
    check("stream_count", 32'(count), 32'd3);
    check("stream_q", 32'(q), 32'h02);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("[TB] backpressure");
    bp_data[0] = 8'h10;
    bp_data[1] = 8'h11;
    bp_data[2] = 8'h12;
    bp_data[3] = 8'h13;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, bp_data[idx], 1'b0);
      if (in_ready) idx++;
    end
    check("bp_count", 32'(count), 32'd3);
    check("bp_q", 32'(q), 32'h10);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_accepted", 32'(idx), 32'd3);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, idx < 4, bp_data[idx < 4 ? idx : 3], 1'b1);
      if (in_ready && idx < 4) idx++;
    end

    $display("[TB] enable");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b1);
    check("en_q", 32'(q), 32'hA0);
    check("en_count", 32'(count), 32'd2);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("[TB] flush");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'hC1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'hC2, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("pre_flush_count", 32'(count), 32'd3);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("[TB] random");
    for (int i = 0; i < 2000; i++) begin
      ri = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 9) != 0);
      rd = 8'($urandom);
      apply_stimulus(1'b1, re, 1'b0, ri, rd, ro);
      assertions++;
      assert (count <= 2'd3)
      else begin
        failures++;
        $error("[TB] FAIL count_bound: observed %0d expected <= 3", count);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
